face_coord_tx: RTL

FACE_COORD_TX -- requirements
Module: face_coord_tx

---
 rtl/face_tx_pkg.sv | 44 ++++
 rtl/uart_tx_byte.sv | 59 +++++
 rtl/face_coord_tx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/face_tx_pkg.sv
// Shared definitions for the face-coordinate UART transmitter.
// FACE_TX_CHECKSUM_EN selects the 7-byte packet with a trailing XOR checksum.
package face_tx_pkg;

  localparam logic [7:0] PKT_HEADER = 8'hA5;

`ifdef FACE_TX_CHECKSUM_EN
  localparam int unsigned PKT_LEN = 7;
`else
  localparam int unsigned PKT_LEN = 6;
`endif

  typedef struct packed {
    logic [3:0]  pyr;
    logic [15:0] row;
    logic [15:0] col;
  } coord_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND_BYTE,
    NEXT_BYTE
  } tx_state_t;

  function automatic logic [7:0] pkt_byte(input coord_entry_t e, input logic [2:0] idx);
    logic [7:0] b;
    b = '1;
    case (idx)
      3'd0: b = PKT_HEADER;
      3'd1: b = {4'h0, e.pyr};
      3'd2: b = e.row[15:8];
      3'd3: b = e.row[7:0];
      3'd4: b = e.col[15:8];
      3'd5: b = e.col[7:0];
`ifdef FACE_TX_CHECKSUM_EN
      3'd6: b = {4'h0, e.pyr} ^ e.row[15:8] ^ e.row[7:0] ^ e.col[15:8] ^ e.col[7:0];
`endif
      default: b = '1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; a new byte may be accepted in the final stop-bit cycle
// so consecutive bytes leave the line with no idle gap.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_done,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic [8:0]       shreg;
  logic             bit_end;
  logic             accept;

  assign bit_end   = busy && (baud_cnt == CNT_LAST);
  assign byte_done = bit_end && (bit_cnt == 4'd9);
  assign accept    = byte_valid && (!busy || byte_done);

  // shreg holds remaining data bits with the stop bit in the MSB
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
    end else if (accept) begin
      busy     <= 1'b1;
      tx       <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= {1'b1, byte_data};
    end else if (busy) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          busy <= 1'b0;
          tx   <= 1'b1;
        end else begin
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/face_coord_tx.sv
// Queues face detections in a FIFO and streams each as a UART packet.
// Packet length depends on FACE_TX_CHECKSUM_EN (see face_tx_pkg).
module face_coord_tx
  import face_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0][31:0] face_coords,
  input  logic             face_coords_ready,
  input  logic [3:0]       pyramid_number,
  output logic             tx,
  output logic             tx_busy,
  output logic             overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);

  coord_entry_t fifo_mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, fill;
  logic         fifo_empty, fifo_full, push, pop;

  tx_state_t    state, state_nxt;
  logic [2:0]   byte_idx, idx_nxt;
  coord_entry_t cur;

  logic         byte_valid, byte_done, ser_busy, byte_accept;
  logic [7:0]   byte_data;

  assign fill       = wr_ptr - rd_ptr;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == (AW+1)'(FIFO_DEPTH));
  // fullness is judged before any same-cycle pop
  assign push       = face_coords_ready && !fifo_full;

  always_ff @(posedge clock) begin
    if (push)
      fifo_mem[wr_ptr[AW-1:0]] <= {pyramid_number, face_coords[0][15:0], face_coords[1][15:0]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      cur      <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (face_coords_ready && fifo_full)
        overflow <= 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cur    <= fifo_mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      byte_idx <= '0;
    end else begin
      state    <= state_nxt;
      byte_idx <= idx_nxt;
    end
  end

  assign byte_data   = pkt_byte(cur, byte_idx);
  assign byte_accept = byte_valid && (byte_done || !ser_busy);

  // next byte is presented while the previous one is still shifting out
  always_comb begin
    state_nxt  = state;
    idx_nxt    = byte_idx;
    pop        = 1'b0;
    byte_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty)
          state_nxt = LOAD;
      end
      LOAD: begin
        pop       = 1'b1;
        idx_nxt   = '0;
        state_nxt = SEND_BYTE;
      end
      SEND_BYTE: begin
        byte_valid = 1'b1;
        if (byte_accept)
          state_nxt = NEXT_BYTE;
      end
      NEXT_BYTE: begin
        if (byte_idx == LAST_IDX) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt   = byte_idx + 3'd1;
          state_nxt = SEND_BYTE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_busy = !fifo_empty || (state != IDLE) || ser_busy;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clock     (clock),
    .reset     (reset),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_done (byte_done),
    .busy      (ser_busy),
    .tx        (tx)
  );

endmodule
